logic_unit: RTL and testbench
=============================

LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 1..64).
REQ-002 SHALL have parameter CNTW, default 8, beat-counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid && in_ready at a rising edge.
REQ-007 SHALL have port op  input  3  operation: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 PASS a.
REQ-008 SHALL have port acc  input  1  start an accumulate sequence (sampled in IDLE only).
REQ-009 SHALL have port last  input  1  final beat of an accumulate sequence.
REQ-010 SHALL have ports a, b  input  WIDTH  operands.
REQ-011 SHALL have port out_valid  output  1  result held in output register.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-013 SHALL have port y  output  WIDTH  result.
REQ-014 SHALL have ports zero (y==0) and parity (XOR-reduce of y)  output  1, registered with y.
REQ-015 SHALL have port beats  output  CNTW  number of beats folded into y.

Function
REQ-016 in_ready SHALL equal !out_valid || out_ready, in every state.
REQ-017 FSM states SHALL be IDLE and ACCUM.
REQ-018 IDLE, accepted beat, acc=0: y<=f(op,a,b), beats<=1, out_valid<=1 on the next edge (latency 1).
REQ-019 IDLE, accepted beat, acc=1, last=0: acc_reg<=f(op,a,b), op latched, count<=1, go ACCUM, no output.
REQ-020 IDLE, acc=1 and last=1 on the same beat: SHALL behave as REQ-018.
REQ-021 ACCUM, accepted beat: acc_reg<=f(op_latched,acc_reg,a); b, op and acc are ignored; count increments, saturating at 2^CNTW-1.
REQ-022 ACCUM, accepted beat with last=1: y<=new acc value, beats<=final count, out_valid<=1, return to IDLE.
REQ-023 out_valid && !out_ready SHALL hold y, zero, parity and beats stable.
REQ-024 Drain and accept in the same cycle SHALL load the new result with out_valid staying 1.
REQ-025 NOT a and PASS a SHALL ignore b in both modes.

Reset
REQ-026 rst SHALL force, without waiting for clk: FSM=IDLE, out_valid=0, y=0, zero=1, parity=0, beats=0, acc_reg=0, count=0.
REQ-027 Reset during ACCUM SHALL discard the partial result; no output is produced for that sequence.

Structure
REQ-028 Op codes and FSM state codes SHALL be defined as constants in shared package logic_unit_pkg.
REQ-029 The op function SHALL be a combinational sub-module logic_op (WIDTH, op, x, z -> r), shared by both modes.

Verification (WIDTH=8)
REQ-030 Beat op=AND, a=F0, b=CC, out_ready=1 -> y=C0, zero=0, parity=0, beats=1, one cycle after accept.
REQ-031 a=A5, b=0F across ops 0..7 -> y = 05, AF, AA, FA, 50, 55, 5A, A5.
REQ-032 AND accumulate: (acc=1, a=FF, b=0F), (a=3C), (a=F4, last=1) -> a single out_valid pulse, y=04, beats=3.
REQ-033 out_ready=0, two beats -> in_ready=0 after the first, y=first result held; out_ready=1 -> second result appears on the next edge.
REQ-034 XOR accumulate of 01, 02, 04 (last on 04) -> y=07, parity=1; a beat with acc=1, op=AND inside the sequence is still XOR-folded.
REQ-035 rst pulsed after 2 accumulate beats -> out_valid=0 immediately; a following acc=0 beat (OR, 00, 00) -> y=00, zero=1, beats=1.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared constants for the logic unit: operation codes and FSM state codes.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOTA = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } lu_state_e;

endpackage

// File: rtl/logic_unit_op.sv
// Combinational bitwise operation r = f(op, x, z), shared by single-beat and
// accumulate modes. NOT and PASS depend on x only.
module logic_op
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] r
);

  // Select the bitwise function by op code
  always_comb begin
    r = x;
    case (op)
      OP_AND:  r = x & z;
      OP_OR:   r = x | z;
      OP_XOR:  r = x ^ z;
      OP_NAND: r = ~(x & z);
      OP_NOR:  r = ~(x | z);
      OP_XNOR: r = ~(x ^ z);
      OP_NOTA: r = ~x;
      OP_PASS: r = x;
      default: r = x;
    endcase
  end

endmodule

// File: rtl/logic_unit.sv
// Logic unit: single-beat bitwise ops or multi-beat accumulate folding, with a
// registered result held until consumed.
//
// Handshake: a beat transfers on a rising edge where in_valid && in_ready; a
// result transfers where out_valid && out_ready. in_ready = !out_valid ||
// out_ready, so a held result blocks input and a drain can coincide with a
// new accept (out_valid then stays 1 with the new result).
module logic_unit
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             last,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity,
  output logic [CNTW-1:0]  beats,
  output lu_state_e        dbg_state
);

  lu_state_e        state_q, state_d;
  logic [WIDTH-1:0] acc_reg_q, acc_reg_d;
  logic [2:0]       op_lat_q, op_lat_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [CNTW-1:0]  beats_q, beats_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [2:0]       f_op;
  logic [WIDTH-1:0] f_x, f_z, f_r;
  logic [CNTW-1:0]  count_sat;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign beats     = beats_q;
  assign dbg_state = state_q;

  // In ACCUM the running value is folded with a under the latched op; b is unused
  always_comb begin
    if (state_q == ST_ACCUM) begin
      f_op = op_lat_q;
      f_x  = acc_reg_q;
      f_z  = a;
    end else begin
      f_op = op;
      f_x  = a;
      f_z  = b;
    end
  end

  logic_op #(.WIDTH(WIDTH)) u_op (
    .op (f_op),
    .x  (f_x),
    .z  (f_z),
    .r  (f_r)
  );

  // Beat counter that sticks at its maximum
  assign count_sat = (&count_q) ? count_q : count_q + CNTW'(1);

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_reg_q   <= '0;
      op_lat_q    <= OP_AND;
      count_q     <= '0;
      y_q         <= '0;
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      beats_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_reg_q   <= acc_reg_d;
      op_lat_q    <= op_lat_d;
      count_q     <= count_d;
      y_q         <= y_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      beats_q     <= beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state: enter ACCUM on a non-final acc beat, leave on the last beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept && acc && !last) state_d = ST_ACCUM;
      ST_ACCUM: if (accept && last)         state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and accumulator updates for the current state and accepted beat
  always_comb begin
    acc_reg_d   = acc_reg_q;
    op_lat_d    = op_lat_q;
    count_d     = count_q;
    y_d         = y_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    beats_d     = beats_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      if (state_q == ST_IDLE) begin
        if (acc && !last) begin
          acc_reg_d = f_r;
          op_lat_d  = op;
          count_d   = CNTW'(1);
        end else begin
          y_d         = f_r;
          zero_d      = (f_r == '0);
          parity_d    = ^f_r;
          beats_d     = CNTW'(1);
          out_valid_d = 1'b1;
        end
      end else begin
        acc_reg_d = f_r;
        count_d   = count_sat;
        if (last) begin
          y_d         = f_r;
          zero_d      = (f_r == '0);
          parity_d    = ^f_r;
          beats_d     = count_sat;
          out_valid_d = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit (WIDTH=8, CNTW=8).
module tb_logic_unit;
  import logic_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic       acc;
  logic       last;
  logic [7:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       parity;
  logic [7:0] beats;
  lu_state_e  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Clock/reset block
  always #5 clk = ~clk;

  logic_unit #(.WIDTH(8), .CNTW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .acc       (acc),
    .last      (last),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .parity    (parity),
    .beats     (beats),
    .dbg_state (dbg_state)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic ac,
                       input logic la, input logic [7:0] av, input logic [7:0] bv);
    in_valid = v;
    op       = o;
    acc      = ac;
    last     = la;
    a        = av;
    b        = bv;
  endtask

  task automatic idle_inputs();
    drive(1'b0, OP_AND, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Output bundle: {out_valid, y, zero, parity, beats}
  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, y, zero, parity, beats} !== {1'b0, 8'h00, 1'b1, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%0b y=%h z=%0b p=%0b beats=%0d want v=0 y=00 z=1 p=0 beats=0",
               out_valid, y, zero, parity, beats);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d in_ready=%0b want state=0 in_ready=1", dbg_state, in_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_and_basic();
    out_ready = 1'b1;
    drive(1'b1, OP_AND, 1'b0, 1'b0, 8'hF0, 8'hCC);
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero, parity, beats} !== {1'b1, 8'hC0, 1'b0, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL and_basic: got v=%0b y=%h z=%0b p=%0b beats=%0d want v=1 y=c0 z=0 p=0 beats=1",
               out_valid, y, zero, parity, beats);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL and_basic_drain: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [7:0] exp_y [8];
    exp_y[0] = 8'h05; exp_y[1] = 8'hAF; exp_y[2] = 8'hAA; exp_y[3] = 8'hFA;
    exp_y[4] = 8'h50; exp_y[5] = 8'h55; exp_y[6] = 8'h5A; exp_y[7] = 8'hA5;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 1'b0, 1'b0, 8'hA5, 8'h0F);
      step();
      n_tests++;
      if ({out_valid, y, zero, parity} !== {1'b1, exp_y[i], 1'b0, ^exp_y[i]}) begin
        n_fail++;
        $display("FAIL all_ops op=%0d: got v=%0b y=%h z=%0b p=%0b want v=1 y=%h z=0 p=%0b",
                 i, out_valid, y, zero, parity, exp_y[i], ^exp_y[i]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_and_accum();
    out_ready = 1'b1;
    drive(1'b1, OP_AND, 1'b1, 1'b0, 8'hFF, 8'h0F);
    step();
    n_tests++;
    if (out_valid !== 1'b0 || dbg_state !== ST_ACCUM) begin
      n_fail++;
      $display("FAIL and_accum_start: got v=%0b state=%0d want v=0 state=1", out_valid, dbg_state);
    end
    drive(1'b1, OP_OR, 1'b0, 1'b0, 8'h3C, 8'hFF);
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL and_accum_mid: got out_valid=%0b want 0", out_valid);
    end
    drive(1'b1, OP_OR, 1'b0, 1'b1, 8'hF4, 8'hFF);
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero, parity, beats} !== {1'b1, 8'h04, 1'b0, 1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL and_accum_result: got v=%0b y=%h z=%0b p=%0b beats=%0d want v=1 y=04 z=0 p=1 beats=3",
               out_valid, y, zero, parity, beats);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL and_accum_single_pulse: got v=%0b state=%0d want v=0 state=0", out_valid, dbg_state);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 1'b0, 1'b0, 8'h01, 8'h02);
    step();
    drive(1'b1, OP_AND, 1'b0, 1'b0, 8'hFF, 8'h0F);
    n_tests++;
    if ({out_valid, y, in_ready} !== {1'b1, 8'h03, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_first: got v=%0b y=%h in_ready=%0b want v=1 y=03 in_ready=0", out_valid, y, in_ready);
    end
    step();
    n_tests++;
    if ({out_valid, y, beats, in_ready} !== {1'b1, 8'h03, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%0b y=%h beats=%0d in_ready=%0b want v=1 y=03 beats=1 in_ready=0",
               out_valid, y, beats, in_ready);
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_comb: got in_ready=%0b want 1", in_ready);
    end
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero} !== {1'b1, 8'h0F, 1'b0}) begin
      n_fail++;
      $display("FAIL bp_second: got v=%0b y=%h z=%0b want v=1 y=0f z=0", out_valid, y, zero);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: got out_valid=%0b want 0", out_valid);
    end
  endtask

  task automatic test_xor_accum();
    out_ready = 1'b1;
    drive(1'b1, OP_XOR, 1'b1, 1'b0, 8'h01, 8'h00);
    step();
    drive(1'b1, OP_AND, 1'b1, 1'b0, 8'h02, 8'h00);
    step();
    drive(1'b1, OP_AND, 1'b0, 1'b1, 8'h04, 8'hFF);
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero, parity, beats} !== {1'b1, 8'h07, 1'b0, 1'b1, 8'd3}) begin
      n_fail++;
      $display("FAIL xor_accum: got v=%0b y=%h z=%0b p=%0b beats=%0d want v=1 y=07 z=0 p=1 beats=3",
               out_valid, y, zero, parity, beats);
    end
    step();
  endtask

  task automatic test_reset_mid_accum();
    out_ready = 1'b1;
    drive(1'b1, OP_OR, 1'b1, 1'b0, 8'h11, 8'h00);
    step();
    drive(1'b1, OP_OR, 1'b0, 1'b0, 8'h22, 8'h00);
    step();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_tests++;
    if ({out_valid, dbg_state, zero, beats} !== {1'b0, ST_IDLE, 1'b1, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_async: got v=%0b state=%0d z=%0b beats=%0d want v=0 state=0 z=1 beats=0",
               out_valid, dbg_state, zero, beats);
    end
    rst = 1'b0;
    step();
    drive(1'b1, OP_OR, 1'b0, 1'b0, 8'h00, 8'h00);
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero, parity, beats} !== {1'b1, 8'h00, 1'b1, 1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL rst_then_beat: got v=%0b y=%h z=%0b p=%0b beats=%0d want v=1 y=00 z=1 p=0 beats=1",
               out_valid, y, zero, parity, beats);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    out_ready = 1'b1;
    exp_q.push_back(8'h3C ^ 8'h0F);
    exp_q.push_back(~(8'h81 | 8'h18));
    exp_q.push_back(8'h00);
    drive(1'b1, OP_XOR, 1'b0, 1'b0, 8'h3C, 8'h0F);
    step();
    drive(1'b1, OP_NOR, 1'b0, 1'b0, 8'h81, 8'h18);
    n_tests++;
    if ({out_valid, y} !== {1'b1, exp_q.pop_front()}) begin
      n_fail++;
      $display("FAIL b2b_0: got v=%0b y=%h want v=1 y=33", out_valid, y);
    end
    step();
    drive(1'b1, OP_NOTA, 1'b0, 1'b0, 8'hFF, 8'h12);
    n_tests++;
    if ({out_valid, y} !== {1'b1, exp_q.pop_front()}) begin
      n_fail++;
      $display("FAIL b2b_1: got v=%0b y=%h want v=1 y=66", out_valid, y);
    end
    step();
    idle_inputs();
    n_tests++;
    if ({out_valid, y, zero} !== {1'b1, exp_q.pop_front(), 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_2: got v=%0b y=%h z=%0b want v=1 y=00 z=1", out_valid, y, zero);
    end
    step();
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle_inputs();
    test_reset();
    test_and_basic();
    test_all_ops();
    test_and_accum();
    test_backpressure();
    test_xor_accum();
    test_reset_mid_accum();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
